// File: rtl/instr_decode_buffer_pkg.sv
// Shared definitions for the two-entry instruction decode buffer:
// instruction field positions, the register-type opcode and buffer occupancy states.
package instr_decode_buffer_pkg;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_decode_buffer_fields.sv
// Combinational field slicer: splits an instruction word into opcode/rs/rt/imm16
// and flags whether the instruction carries an immediate.
module instr_fields
  import instr_decode_buffer_pkg::*;
#(
  parameter logic [5:0] OPC_RTYPE = instr_decode_buffer_pkg::OPC_RTYPE
) (
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm16,
  output logic        uses_imm
);

  always_comb begin
    opcode   = instr[OPC_MSB:OPC_LSB];
    rs       = instr[RS_MSB:RS_LSB];
    rt       = instr[RT_MSB:RT_LSB];
    imm16    = instr[IMM_MSB:IMM_LSB];
    uses_imm = (instr[OPC_MSB:OPC_LSB] != OPC_RTYPE);
  end

endmodule

// File: rtl/instr_decode_buffer.sv
// Two-entry FIFO between fetch and decode; presents the head entry's decoded
// fields, zeroed whenever the buffer is empty.
module instr_decode_buffer
  import instr_decode_buffer_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter logic [5:0]  OPC_RTYPE = instr_decode_buffer_pkg::OPC_RTYPE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [15:0]     imm16,
  output logic            uses_imm,
  output logic [PC_W-1:0] out_pc
);

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [31:0]     instr_mem_q [2];
  logic [31:0]     instr_mem_d [2];
  logic [PC_W-1:0] pc_mem_q [2];
  logic [PC_W-1:0] pc_mem_d [2];

  logic push, pop;

  logic [31:0] head_instr;
  logic [5:0]  f_opcode;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [15:0] f_imm16;
  logic        f_uses_imm;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    // in_ready_q is already low in FULL, so push never coincides with FULL
    push = in_valid && in_ready_q && !flush;
    pop  = (state_q != EMPTY) && out_ready && !flush;

    if (push) begin
      instr_mem_d[wr_ptr_q] = in_instr;
      pc_mem_d[wr_ptr_q]    = in_pc;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d  = EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is not reset: entries are only observable through valid state.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  assign head_instr = instr_mem_q[rd_ptr_q];

  instr_fields #(
    .OPC_RTYPE (OPC_RTYPE)
  ) u_fields (
    .instr    (head_instr),
    .opcode   (f_opcode),
    .rs       (f_rs),
    .rt       (f_rt),
    .imm16    (f_imm16),
    .uses_imm (f_uses_imm)
  );

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q != EMPTY);
    opcode    = out_valid ? f_opcode   : '0;
    rs        = out_valid ? f_rs       : '0;
    rt        = out_valid ? f_rt       : '0;
    imm16     = out_valid ? f_imm16    : '0;
    uses_imm  = out_valid ? f_uses_imm : 1'b0;
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Bench for instr_decode_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_instr_decode_buffer;

  localparam int unsigned PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [15:0]     imm16;
  logic            uses_imm;
  logic [PC_W-1:0] out_pc;

  always #5 clk = ~clk;

  instr_decode_buffer #(
    .PC_W      (PC_W),
    .OPC_RTYPE (6'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .imm16     (imm16),
    .uses_imm  (uses_imm),
    .out_pc    (out_pc)
  );

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t m_q[$];
  logic   m_rdy = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] w;
    w = (m_q.size() > 0) ? m_q[0].instr : 32'h0;
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    check("opcode", 64'(opcode), 64'(w >> 26));
    check("rs", 64'(rs), 64'((w >> 21) & 32'h1f));
    check("rt", 64'(rt), 64'((w >> 16) & 32'h1f));
    check("imm16", 64'(imm16), 64'(w & 32'hffff));
    check("uses_imm", 64'(uses_imm), 64'((m_q.size() > 0) && ((w >> 26) != 0)));
    check("out_pc", 64'(out_pc), 64'((m_q.size() > 0) ? m_q[0].pc : '0));
  endtask

  task automatic cycle(input logic v, input logic rdy, input logic fl, input logic rn,
                       input logic [31:0] ins, input logic [PC_W-1:0] pc);
    entry_t e;
    logic   do_push, do_pop;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    rst_n     = rn;
    in_instr  = ins;
    in_pc     = pc;
    @(posedge clk);
    if (!rn || fl) begin
      m_q.delete();
      m_rdy = 1'b1;
    end else begin
      do_push = v && m_rdy;
      do_pop  = rdy && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.instr = ins;
        e.pc    = pc;
        m_q.push_back(e);
      end
      m_rdy = (m_q.size() < 2);
    end
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] r;
    in_valid = 0; out_ready = 0; flush = 0; rst_n = 0; in_instr = '0; in_pc = '0;

    cycle(0, 0, 0, 0, 32'h0, '0);
    cycle(0, 0, 0, 0, 32'h0, '0);

    cycle(1, 1, 0, 1, 32'h2422FFFC, 32'h100);
    check("rst_push_valid", 64'(out_valid), 64'd1);
    check("rst_push_opc", 64'(opcode), 64'h09);
    check("rst_push_rs", 64'(rs), 64'd1);
    check("rst_push_rt", 64'(rt), 64'd2);
    check("rst_push_imm", 64'(imm16), 64'hFFFC);
    check("rst_push_uimm", 64'(uses_imm), 64'd1);
    check("rst_push_pc", 64'(out_pc), 64'h100);
    cycle(0, 1, 0, 1, 32'h0, '0);
    check("after_pop_valid", 64'(out_valid), 64'd0);

    cycle(1, 0, 0, 1, 32'h00430820, 32'h4);
    check("rtype_opc", 64'(opcode), 64'h0);
    check("rtype_rs", 64'(rs), 64'd2);
    check("rtype_rt", 64'(rt), 64'd3);
    check("rtype_imm", 64'(imm16), 64'h0820);
    check("rtype_uimm", 64'(uses_imm), 64'd0);
    // push+pop in ONE: new entry becomes head
    cycle(1, 1, 0, 1, 32'h8C000001, 32'h8);
    check("pushpop_pc", 64'(out_pc), 64'h8);
    check("pushpop_rdy", 64'(in_ready), 64'd1);
    cycle(0, 1, 0, 1, 32'h0, '0);

    // backpressure fill A, B, then C held until a pop frees space
    cycle(1, 0, 0, 1, 32'h20000000, 32'h0);
    cycle(1, 0, 0, 1, 32'h20000001, 32'h4);
    check("full_rdy", 64'(in_ready), 64'd0);
    cycle(1, 0, 0, 1, 32'h20000002, 32'h8);
    cycle(1, 1, 0, 1, 32'h20000002, 32'h8);
    check("drain_b_pc", 64'(out_pc), 64'h4);
    cycle(1, 1, 0, 1, 32'h20000002, 32'h8);
    check("drain_c_pc", 64'(out_pc), 64'h8);
    cycle(0, 1, 0, 1, 32'h0, '0);

    // flush while FULL with an incoming instruction
    cycle(1, 0, 0, 1, 32'h30000000, 32'h10);
    cycle(1, 0, 0, 1, 32'h30000001, 32'h14);
    cycle(1, 0, 1, 1, 32'h30000002, 32'h18);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_rdy", 64'(in_ready), 64'd1);
    cycle(0, 1, 0, 1, 32'h0, '0);

    // reset while FULL
    cycle(1, 0, 0, 1, 32'h40000000, 32'h20);
    cycle(1, 0, 0, 1, 32'h40000001, 32'h24);
    cycle(1, 0, 0, 0, 32'h40000002, 32'h28);
    cycle(0, 1, 0, 1, 32'h0, '0);
    check("rst_mid_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[31:26] = 6'h00;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 59) != 0),
            r, PC_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_buffer.md
INSTR_DECODE_BUFFER -- requirements
Module: instr_decode_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning the width of the program-counter tag carried with each instruction.
REQ-002 SHALL have parameter OPC_RTYPE, default 6'h00, meaning the opcode value that marks register-type (no-immediate) instructions.
REQ-003 SHALL use a single clock and a synchronous, active-low reset, per these port lines:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  buffer can accept (registered).
- in_instr  input  32  instruction word.
- in_pc  input  PC_W  address of in_instr.
- flush  input  1  synchronous discard of all held entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head.
- opcode  output  6  head instr[31:26].
- rs  output  5  head instr[25:21].
- rt  output  5  head instr[20:16].
- imm16  output  16  head instr[15:0], raw; feeds the downstream sign-extension stage unmodified.
- uses_imm  output  1  head opcode != OPC_RTYPE.
- out_pc  output  PC_W  head PC tag.

Function
REQ-004 SHALL hold up to 2 entries {instr, pc} in FIFO order.
REQ-005 SHALL use states EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
REQ-006 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
- EMPTY: push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, with the new entry at the head.
- FULL: pop -> ONE; push is impossible.
REQ-007 in_ready SHALL be a registered signal equal to (next state != FULL); no combinational path SHALL exist from out_ready to in_ready.
REQ-008 out_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-009 Latency SHALL be one cycle: an entry pushed at edge N SHALL be visible at the outputs after edge N, when it is the head.
REQ-010 opcode, rs, rt, imm16, uses_imm and out_pc SHALL be driven from the head entry when out_valid=1, and SHALL be all zero when out_valid=0.
REQ-011 Head outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 A flush SHALL take priority over push and pop: the next state is EMPTY, the input in that cycle is dropped, and in_ready=1 after the edge.
REQ-013 Storage pointers SHALL wrap modulo 2, and order SHALL be preserved across wrap.
REQ-014 Field extraction SHALL be pure bit-slicing, with no arithmetic and no sign handling.

Reset
REQ-015 While rst_n=0 at a rising edge, the state SHALL become EMPTY, out_valid=0, in_ready=1, and all field outputs 0.
REQ-016 A reset asserted mid-operation SHALL discard held entries exactly as a flush does; stored data contents are don't-care.
REQ-017 The first push SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-018 The shared package SHALL hold: the instruction field bit-position constants, OPC_RTYPE, and the state enum typedef {EMPTY, ONE, FULL}.
REQ-019 The design SHALL contain one sub-module, instr_fields, a combinational slicer (instr -> opcode/rs/rt/imm16/uses_imm) instantiated on the head entry; all state SHALL reside in instr_decode_buffer.

Verification
REQ-020 Reset -> single push: hold rst_n=0 for 2 cycles, then push instr 32'h2422FFFC with pc 32'h100 and out_ready=1 -> next cycle out_valid=1, opcode=6'h09, rs=1, rt=2, imm16=16'hFFFC, uses_imm=1, out_pc=32'h100; the following cycle out_valid=0 and all fields 0.
REQ-021 Backpressure fill: out_ready=0, push A (pc 0x0), B (pc 0x4), C (pc 0x8) back-to-back -> A and B accepted, in_ready=0 after the 2nd push, C not accepted until 1 cycle after the first pop; drain order is A, B, C.
REQ-022 Simultaneous push/pop in ONE: head A, push B with out_ready=1 -> next cycle the head is B and the state is ONE, with in_ready=1 throughout.
REQ-023 Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle instruction is never output.
REQ-024 R-type: push 32'h00430820 -> opcode=0, rs=2, rt=3, imm16=16'h0820, uses_imm=0.
REQ-025 Reset mid-stream: assert rst_n=0 for 1 cycle while in FULL -> state EMPTY, with no stale entry appearing after the release.
